axi_write_arbiter: RTL and testbench

//  Write-path arbiter directly upstream of the AXI write-channel mux. Decodes each master's AWADDR, arbitrates

---
 rtl/axi_write_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_axi_write_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_write_arbiter.sv
// axi_write_arbiter: per-slave AXI write-path arbiter that holds each grant from AW through the B handshake.
// Optional WARB_ROUND_ROBIN_EN selects per-slave round-robin; otherwise the lowest master index wins.
`default_nettype none

module axi_write_arbiter #(
  parameter int NUM_M     = 3,
  parameter int NUM_S     = 6,
  parameter int MIDX_BITS = 2,
  parameter int SIDX_BITS = 3
) (
  input  logic                                ACLK,
  input  logic                                ARESETn,
  input  logic [NUM_M-1:0][31:0]              AWADDR_M,
  input  logic [NUM_M-1:0]                    AWVALID_M,
  input  logic [NUM_M-1:0]                    AWREADY_M,
  input  logic [NUM_M-1:0]                    WVALID_M,
  input  logic [NUM_M-1:0]                    WREADY_M,
  input  logic [NUM_M-1:0]                    WLAST_M,
  input  logic [NUM_M-1:0]                    BVALID_M,
  input  logic [NUM_M-1:0]                    BREADY_M,
  output logic [NUM_S:0][MIDX_BITS-1:0]       SWIdx,
  output logic [NUM_M-1:0][SIDX_BITS-1:0]     MWIdx
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AW   = 2'd1,
    ST_W    = 2'd2,
    ST_B    = 2'd3
  } state_t;

  state_t               r_state     [NUM_M];
  state_t               w_state_nxt [NUM_M];
  logic [SIDX_BITS-1:0] r_target    [NUM_M];
  logic [SIDX_BITS-1:0] w_dec       [NUM_M];
  logic [NUM_M-1:0]     w_granted;
  logic [NUM_M-1:0]     w_release;

  logic [NUM_S:0]       r_busy;
  logic [MIDX_BITS-1:0] r_owner     [NUM_S+1];
  logic [NUM_S:0]       w_gnt;
  logic [MIDX_BITS-1:0] w_gnt_idx   [NUM_S+1];
  logic [NUM_S:0]       w_slave_rel;

`ifdef WARB_ROUND_ROBIN_EN
  logic [MIDX_BITS-1:0] r_ptr       [NUM_S+1];
`endif

  function automatic logic [SIDX_BITS-1:0] decode(input logic [31:0] a);
    if (a <= 32'h0000_3FFF)                              return SIDX_BITS'(0);
    if (a >= 32'h0001_0000 && a <= 32'h0001_FFFF)       return SIDX_BITS'(1);
    if (a >= 32'h0002_0000 && a <= 32'h0002_FFFF)       return SIDX_BITS'(2);
    if (a >= 32'h1002_0000 && a <= 32'h1002_03FF)       return SIDX_BITS'(3);
    if (a >= 32'h1001_0000 && a <= 32'h1001_03FF)       return SIDX_BITS'(4);
    if (a >= 32'h2000_0000 && a <= 32'h201F_FFFF)       return SIDX_BITS'(5);
    return SIDX_BITS'(NUM_S);
  endfunction

  always_comb begin
    for (int m = 0; m < NUM_M; m++) begin
      w_dec[m] = decode(AWADDR_M[m]);
    end
  end

  // Grant only free slaves; a slave released this edge stays busy until after it.
  always_comb begin
    for (int s = 0; s <= NUM_S; s++) begin
      w_gnt[s]     = 1'b0;
      w_gnt_idx[s] = '0;
      for (int m = NUM_M - 1; m >= 0; m--) begin
        if (!r_busy[s] && r_state[m] == ST_IDLE && AWVALID_M[m] && w_dec[m] == SIDX_BITS'(s)) begin
          w_gnt[s]     = 1'b1;
          w_gnt_idx[s] = MIDX_BITS'(m);
        end
      end
`ifdef WARB_ROUND_ROBIN_EN
      // Second pass prefers the lowest requester at or above the pointer, wrapping to the first pass result.
      for (int m = NUM_M - 1; m >= 0; m--) begin
        if (!r_busy[s] && r_state[m] == ST_IDLE && AWVALID_M[m] && w_dec[m] == SIDX_BITS'(s) &&
            MIDX_BITS'(m) >= r_ptr[s]) begin
          w_gnt_idx[s] = MIDX_BITS'(m);
        end
      end
`endif
    end
  end

  always_comb begin
    for (int m = 0; m < NUM_M; m++) begin
      w_granted[m] = 1'b0;
      for (int s = 0; s <= NUM_S; s++) begin
        if (w_gnt[s] && w_gnt_idx[s] == MIDX_BITS'(m)) w_granted[m] = 1'b1;
      end
    end
  end

  always_comb begin
    for (int m = 0; m < NUM_M; m++) begin
      w_state_nxt[m] = r_state[m];
      w_release[m]   = 1'b0;
      case (r_state[m])
        ST_IDLE: if (w_granted[m]) w_state_nxt[m] = ST_AW;
        ST_AW:   if (AWVALID_M[m] && AWREADY_M[m]) w_state_nxt[m] = ST_W;
        ST_W:    if (WVALID_M[m] && WREADY_M[m] && WLAST_M[m]) w_state_nxt[m] = ST_B;
        ST_B: begin
          if (BVALID_M[m] && BREADY_M[m]) begin
            w_state_nxt[m] = ST_IDLE;
            w_release[m]   = 1'b1;
          end
        end
        default: w_state_nxt[m] = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    for (int s = 0; s <= NUM_S; s++) begin
      w_slave_rel[s] = 1'b0;
      for (int m = 0; m < NUM_M; m++) begin
        if (w_release[m] && r_target[m] == SIDX_BITS'(s)) w_slave_rel[s] = 1'b1;
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      for (int m = 0; m < NUM_M; m++) begin
        r_state[m]  <= ST_IDLE;
        r_target[m] <= '0;
      end
    end else begin
      for (int m = 0; m < NUM_M; m++) begin
        r_state[m] <= w_state_nxt[m];
        if (w_granted[m]) r_target[m] <= w_dec[m];
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_busy <= '0;
      for (int s = 0; s <= NUM_S; s++) begin
        r_owner[s] <= '0;
      end
    end else begin
      for (int s = 0; s <= NUM_S; s++) begin
        if (r_busy[s] && w_slave_rel[s]) begin
          r_busy[s] <= 1'b0;
        end else if (w_gnt[s]) begin
          r_busy[s]  <= 1'b1;
          r_owner[s] <= w_gnt_idx[s];
        end
      end
    end
  end

`ifdef WARB_ROUND_ROBIN_EN
  // Pointer holds the first master to consider at the next contest for this slave.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      for (int s = 0; s <= NUM_S; s++) begin
        r_ptr[s] <= '0;
      end
    end else begin
      for (int s = 0; s <= NUM_S; s++) begin
        if (w_gnt[s]) begin
          r_ptr[s] <= (w_gnt_idx[s] == MIDX_BITS'(NUM_M - 1)) ? '0 : w_gnt_idx[s] + 1'b1;
        end
      end
    end
  end
`endif

  always_comb begin
    for (int s = 0; s <= NUM_S; s++) begin
      SWIdx[s] = r_busy[s] ? r_owner[s] : MIDX_BITS'(NUM_M);
    end
    for (int m = 0; m < NUM_M; m++) begin
      MWIdx[m] = (r_state[m] != ST_IDLE) ? r_target[m] : SIDX_BITS'(NUM_S + 1);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_axi_write_arbiter.sv
// Testbench for axi_write_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
`default_nettype none

module tb_axi_write_arbiter;
  localparam int NM = 3;
  localparam int NS = 6;
`ifdef WARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  localparam logic [31:0] LO [6] = '{32'h0000_0000, 32'h0001_0000, 32'h0002_0000,
                                     32'h1002_0000, 32'h1001_0000, 32'h2000_0000};
  localparam logic [31:0] HI [6] = '{32'h0000_3FFF, 32'h0001_FFFF, 32'h0002_FFFF,
                                     32'h1002_03FF, 32'h1001_03FF, 32'h201F_FFFF};
  localparam logic [31:0] ADDRS [16] = '{32'h0000_0000, 32'h0000_3FFF, 32'h0000_4000, 32'h0001_0000,
                                         32'h0001_FFFF, 32'h0002_0000, 32'h0002_FFFF, 32'h0003_0000,
                                         32'h1002_0000, 32'h1002_03FF, 32'h1002_0400, 32'h1001_0000,
                                         32'h1001_03FF, 32'h2000_0000, 32'h201F_FFFF, 32'h2020_0000};

  logic                  ACLK = 1'b0;
  logic                  ARESETn;
  logic [NM-1:0][31:0]   AWADDR_M;
  logic [NM-1:0]         AWVALID_M, AWREADY_M, WVALID_M, WREADY_M, WLAST_M, BVALID_M, BREADY_M;
  logic [NS:0][1:0]      SWIdx;
  logic [NM-1:0][2:0]    MWIdx;

  int checks = 0;
  int errors = 0;

  // Model: who owns each slave (-1 free), per-master phase 0 idle/1 AW/2 W/3 B, target, rr start.
  int mo_owner [NS+1];
  int mo_phase [NM];
  int mo_tgt   [NM];
  int mo_rr    [NS+1];

  axi_write_arbiter dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .AWADDR_M(AWADDR_M), .AWVALID_M(AWVALID_M),
    .AWREADY_M(AWREADY_M), .WVALID_M(WVALID_M), .WREADY_M(WREADY_M), .WLAST_M(WLAST_M),
    .BVALID_M(BVALID_M), .BREADY_M(BREADY_M), .SWIdx(SWIdx), .MWIdx(MWIdx)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired got running want finished");
    $fatal(1);
  end

  function automatic int ref_decode(input logic [31:0] a);
    for (int i = 0; i < 6; i++) if (a >= LO[i] && a <= HI[i]) return i;
    return NS;
  endfunction

  function automatic int exp_sw(input int s);
    return (mo_owner[s] < 0) ? NM : mo_owner[s];
  endfunction

  function automatic int exp_mw(input int m);
    return (mo_phase[m] == 0) ? NS + 1 : mo_tgt[m];
  endfunction

  task automatic model_reset();
    for (int s = 0; s <= NS; s++) begin mo_owner[s] = -1; mo_rr[s] = 0; end
    for (int m = 0; m < NM; m++) begin mo_phase[m] = 0; mo_tgt[m] = 0; end
  endtask

  task automatic model_step();
    int n_owner [NS+1];
    int n_phase [NM];
    n_owner = mo_owner;
    n_phase = mo_phase;
    for (int m = 0; m < NM; m++) begin
      case (mo_phase[m])
        1: if (AWVALID_M[m] && AWREADY_M[m]) n_phase[m] = 2;
        2: if (WVALID_M[m] && WREADY_M[m] && WLAST_M[m]) n_phase[m] = 3;
        3: if (BVALID_M[m] && BREADY_M[m]) begin n_phase[m] = 0; n_owner[mo_tgt[m]] = -1; end
        default: ;
      endcase
    end
    for (int s = 0; s <= NS; s++) begin
      if (mo_owner[s] < 0) begin
        bit found = 1'b0;
        int start = RR ? mo_rr[s] : 0;
        for (int k = 0; k < NM; k++) begin
          int m = (start + k) % NM;
          if (!found && mo_phase[m] == 0 && AWVALID_M[m] && ref_decode(AWADDR_M[m]) == s) begin
            found      = 1'b1;
            n_owner[s] = m;
            n_phase[m] = 1;
            mo_tgt[m]  = s;
            mo_rr[s]   = (m + 1) % NM;
          end
        end
      end
    end
    mo_owner = n_owner;
    mo_phase = n_phase;
  endtask

  task automatic cycle();
    if (!ARESETn) model_reset(); else model_step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic clear_inputs();
    AWADDR_M = '0; AWVALID_M = '0; AWREADY_M = '0; WVALID_M = '0;
    WREADY_M = '0; WLAST_M = '0; BVALID_M = '0; BREADY_M = '0;
  endtask

  task automatic test_reset();
    ARESETn = 1'b0; clear_inputs(); model_reset();
    cycle(); cycle();
    for (int s = 0; s <= NS; s++) begin
      checks++;
      if (SWIdx[s] !== 2'd3) begin errors++; $display("FAIL reset_sw[%0d] got %0d want 3", s, SWIdx[s]); end
    end
    ARESETn = 1'b1;
    cycle();
    AWADDR_M[0] = 32'h0002_0000; AWVALID_M[0] = 1'b1;
    cycle();
    AWREADY_M[0] = 1'b1;
    cycle();
    AWVALID_M[0] = 1'b0; AWREADY_M[0] = 1'b0; WVALID_M[0] = 1'b1; WREADY_M[0] = 1'b1;
    cycle();
    checks++;
    if (MWIdx[0] !== 3'd2) begin errors++; $display("FAIL reset_preburst_mw0 got %0d want 2", MWIdx[0]); end
    ARESETn = 1'b0;
    #1;
    model_reset();
    for (int s = 0; s <= NS; s++) begin
      checks++;
      if (SWIdx[s] !== 2'd3) begin errors++; $display("FAIL async_reset_sw[%0d] got %0d want 3", s, SWIdx[s]); end
    end
    for (int m = 0; m < NM; m++) begin
      checks++;
      if (MWIdx[m] !== 3'd7) begin errors++; $display("FAIL async_reset_mw[%0d] got %0d want 7", m, MWIdx[m]); end
    end
    cycle();
    ARESETn = 1'b1; clear_inputs();
    cycle(); cycle(); cycle();
    for (int s = 0; s <= NS; s++) begin
      checks++;
      if (SWIdx[s] !== 2'd3) begin errors++; $display("FAIL post_reset_sw[%0d] got %0d want 3", s, SWIdx[s]); end
    end
  endtask

  task automatic test_single();
    clear_inputs();
    AWADDR_M[1] = 32'h0002_0010; AWVALID_M[1] = 1'b1;
    cycle();
    checks++;
    if (SWIdx[2] !== 2'd1 || MWIdx[1] !== 3'd2) begin
      errors++; $display("FAIL single_grant got sw=%0d mw=%0d want sw=1 mw=2", SWIdx[2], MWIdx[1]);
    end
    AWREADY_M[1] = 1'b1;
    cycle();
    AWVALID_M[1] = 1'b0; AWREADY_M[1] = 1'b0;
    for (int beat = 0; beat < 4; beat++) begin
      WVALID_M[1] = 1'b1; WREADY_M[1] = 1'b1; WLAST_M[1] = (beat == 3);
      BVALID_M[1] = (beat < 2); BREADY_M[1] = (beat < 2);
      cycle();
      checks++;
      if (SWIdx[2] !== 2'd1 || MWIdx[1] !== 3'd2) begin
        errors++; $display("FAIL single_hold beat %0d got sw=%0d mw=%0d want sw=1 mw=2", beat, SWIdx[2], MWIdx[1]);
      end
    end
    WVALID_M[1] = 1'b0; WREADY_M[1] = 1'b0; WLAST_M[1] = 1'b0; BVALID_M[1] = 1'b1; BREADY_M[1] = 1'b0;
    cycle();
    checks++;
    if (SWIdx[2] !== 2'd1) begin errors++; $display("FAIL single_b_wait got %0d want 1", SWIdx[2]); end
    BREADY_M[1] = 1'b1;
    cycle();
    checks++;
    if (SWIdx[2] !== 2'd3 || MWIdx[1] !== 3'd7) begin
      errors++; $display("FAIL single_release got sw=%0d mw=%0d want sw=3 mw=7", SWIdx[2], MWIdx[1]);
    end
    clear_inputs();
  endtask

  task automatic test_contention();
    clear_inputs();
    AWADDR_M[0] = 32'h0001_0000; AWADDR_M[1] = 32'h0001_0000; AWVALID_M = 3'b011;
    cycle();
    checks++;
    if (SWIdx[1] !== 2'd0 || MWIdx[0] !== 3'd1 || MWIdx[1] !== 3'd7) begin
      errors++; $display("FAIL contend_first got sw=%0d mw0=%0d mw1=%0d want 0 1 7", SWIdx[1], MWIdx[0], MWIdx[1]);
    end
    AWREADY_M = 3'b011;
    cycle();
    AWVALID_M[0] = 1'b0; AWREADY_M = '0; WVALID_M[0] = 1'b1; WREADY_M[0] = 1'b1; WLAST_M[0] = 1'b1;
    cycle();
    WVALID_M = '0; WREADY_M = '0; WLAST_M = '0; BVALID_M[0] = 1'b1; BREADY_M[0] = 1'b1;
    cycle();
    checks++;
    if (SWIdx[1] !== 2'd3 || MWIdx[1] !== 3'd7) begin
      errors++; $display("FAIL contend_release_edge got sw=%0d mw1=%0d want 3 7", SWIdx[1], MWIdx[1]);
    end
    BVALID_M = '0; BREADY_M = '0;
    cycle();
    checks++;
    if (SWIdx[1] !== 2'd1 || MWIdx[1] !== 3'd1) begin
      errors++; $display("FAIL contend_second got sw=%0d mw1=%0d want 1 1", SWIdx[1], MWIdx[1]);
    end
    AWREADY_M[1] = 1'b1;
    cycle();
    AWVALID_M = '0; AWREADY_M = '0; WVALID_M[1] = 1'b1; WREADY_M[1] = 1'b1; WLAST_M[1] = 1'b1;
    cycle();
    WVALID_M = '0; WREADY_M = '0; WLAST_M = '0; BVALID_M[1] = 1'b1; BREADY_M[1] = 1'b1;
    cycle();
    checks++;
    if (SWIdx[1] !== 2'd3) begin errors++; $display("FAIL contend_done got %0d want 3", SWIdx[1]); end
    clear_inputs();
  endtask

  task automatic test_concurrent();
    clear_inputs();
    AWADDR_M[0] = 32'h0002_0000; AWADDR_M[1] = 32'h2000_0000; AWVALID_M = 3'b011;
    cycle();
    checks++;
    if (SWIdx[2] !== 2'd0 || SWIdx[5] !== 2'd1 || MWIdx[0] !== 3'd2 || MWIdx[1] !== 3'd5) begin
      errors++; $display("FAIL concurrent_grant got sw2=%0d sw5=%0d mw0=%0d mw1=%0d want 0 1 2 5",
                         SWIdx[2], SWIdx[5], MWIdx[0], MWIdx[1]);
    end
    AWREADY_M = 3'b011;
    cycle();
    AWVALID_M = '0; AWREADY_M = '0; WVALID_M = 3'b011; WREADY_M = 3'b011; WLAST_M = 3'b011;
    cycle();
    WVALID_M = '0; WREADY_M = '0; WLAST_M = '0; BVALID_M = 3'b010; BREADY_M = 3'b010;
    cycle();
    checks++;
    if (SWIdx[5] !== 2'd3 || SWIdx[2] !== 2'd0) begin
      errors++; $display("FAIL concurrent_indep got sw5=%0d sw2=%0d want 3 0", SWIdx[5], SWIdx[2]);
    end
    BVALID_M = 3'b001; BREADY_M = 3'b001;
    cycle();
    checks++;
    if (SWIdx[2] !== 2'd3 || MWIdx[0] !== 3'd7) begin
      errors++; $display("FAIL concurrent_done got sw2=%0d mw0=%0d want 3 7", SWIdx[2], MWIdx[0]);
    end
    clear_inputs();
  endtask

  task automatic test_default();
    clear_inputs();
    AWADDR_M[2] = 32'h3000_0000; AWVALID_M[2] = 1'b1;
    cycle();
    checks++;
    if (SWIdx[6] !== 2'd2 || MWIdx[2] !== 3'd6) begin
      errors++; $display("FAIL default_grant got sw=%0d mw=%0d want 2 6", SWIdx[6], MWIdx[2]);
    end
    AWVALID_M[2] = 1'b0; AWREADY_M[2] = 1'b1;
    cycle(); cycle();
    checks++;
    if (SWIdx[6] !== 2'd2 || MWIdx[2] !== 3'd6) begin
      errors++; $display("FAIL default_hold_awdrop got sw=%0d mw=%0d want 2 6", SWIdx[6], MWIdx[2]);
    end
    AWVALID_M[2] = 1'b1;
    cycle();
    AWVALID_M = '0; AWREADY_M = '0; WVALID_M[2] = 1'b1; WREADY_M[2] = 1'b1; WLAST_M[2] = 1'b1;
    cycle();
    WVALID_M = '0; WREADY_M = '0; WLAST_M = '0; BVALID_M[2] = 1'b1; BREADY_M[2] = 1'b1;
    cycle();
    checks++;
    if (SWIdx[6] !== 2'd3 || MWIdx[2] !== 3'd7) begin
      errors++; $display("FAIL default_release got sw=%0d mw=%0d want 3 7", SWIdx[6], MWIdx[2]);
    end
    clear_inputs();
  endtask

  task automatic test_rr();
    int winners[$];
    logic [1:0] prev;
    ARESETn = 1'b0; clear_inputs();
    cycle();
    ARESETn = 1'b1;
    AWADDR_M[0] = 32'h0001_0000; AWADDR_M[1] = 32'h0001_0000;
    AWVALID_M = 3'b011; AWREADY_M = 3'b011; WVALID_M = 3'b011; WREADY_M = 3'b011;
    WLAST_M = 3'b011; BVALID_M = 3'b011; BREADY_M = 3'b011;
    prev = 2'd3;
    for (int c = 0; c < 40 && winners.size() < 4; c++) begin
      cycle();
      if (SWIdx[1] !== 2'd3 && prev === 2'd3) winners.push_back(int'(SWIdx[1]));
      prev = SWIdx[1];
    end
    if (winners.size() < 4) begin
      checks++; errors++;
      $display("FAIL rr_timeout got %0d grants want 4", winners.size());
    end
    foreach (winners[i]) begin
      int want = RR ? (i % 2) : 0;
      checks++;
      if (winners[i] != want) begin errors++; $display("FAIL rr_winner[%0d] got %0d want %0d", i, winners[i], want); end
    end
    clear_inputs();
  endtask

  task automatic test_random();
    ARESETn = 1'b0; clear_inputs();
    cycle();
    ARESETn = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      for (int m = 0; m < NM; m++) begin
        int k = $urandom_range(0, 16);
        if (k == 16) AWADDR_M[m] = $urandom;
        else         AWADDR_M[m] = ADDRS[k];
      end
      AWVALID_M = 3'($urandom); AWREADY_M = 3'($urandom); WVALID_M = 3'($urandom);
      WREADY_M = 3'($urandom); WLAST_M = 3'($urandom); BVALID_M = 3'($urandom); BREADY_M = 3'($urandom);
      ARESETn = ($urandom_range(0, 199) != 0);
      cycle();
      for (int s = 0; s <= NS; s++) begin
        checks++;
        if (SWIdx[s] !== 2'(exp_sw(s))) begin
          errors++; $display("FAIL rand_sw[%0d] cyc %0d got %0d want %0d", s, c, SWIdx[s], exp_sw(s));
        end
      end
      for (int m = 0; m < NM; m++) begin
        checks++;
        if (MWIdx[m] !== 3'(exp_mw(m))) begin
          errors++; $display("FAIL rand_mw[%0d] cyc %0d got %0d want %0d", m, c, MWIdx[m], exp_mw(m));
        end
      end
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_concurrent();
    test_default();
    test_rr();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
